oup_ulpi_link: RTL and testbench

OUP_ULPI_LINK -- requirements
Module: oup_ulpi_link

---
 rtl/oup_ulpi_link.sv | 190 +++++++++++++++++++
 tb/tb_oup_ulpi_link.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oup_ulpi_link.sv
// ULPI link-side PHY register access engine (immediate address read/write) with bus abort/retry and timeout.
// Define OUP_ULPI_RXCMD_EN to expose received RX CMD bytes on rxcmd_o / rxcmd_vld_o.
module oup_ulpi_link #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       ulpi_clk_i,
   input  logic       rst_i,
   input  logic       req_i,
   input  logic       we_i,
   input  logic [5:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   output logic       done_o,
   output logic       err_o,
   output logic       busy_o,
   output logic [7:0] rxcmd_o,
   output logic       rxcmd_vld_o,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_data_oe_o,
   input  logic       ulpi_dir_i,
   input  logic       ulpi_nxt_i,
   output logic       ulpi_stp_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, TXCMD, WDATA, STP, RTURN, RDATA, RBACK, ABORT, RXBUS
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [5:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          tmo_stp_q, tmo_stp_d;
   logic          drive_q, drive_d;
   logic          counting;
   logic          tmo;

   // Only an active register transaction is timed; RX bus ownership is not.
   assign counting = state_q inside {TXCMD, WDATA, RTURN, RDATA, RBACK, ABORT};
   assign tmo      = counting && (cnt_q == CNT_LAST);

   always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tmo) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // A request still held during the done/err cycle is the one just finished.
               if (ulpi_dir_i) begin
                  state_d = RXBUS;
               end else if (req_i && !done_q && !err_q) begin
                  state_d = TXCMD;
               end
            end
            TXCMD: begin
               if (ulpi_dir_i) begin
                  state_d = ABORT;
               end else if (ulpi_nxt_i) begin
                  state_d = we_q ? WDATA : RTURN;
               end
            end
            WDATA: begin
               if (ulpi_dir_i) begin
                  state_d = ABORT;
               end else if (ulpi_nxt_i) begin
                  state_d = STP;
               end
            end
            STP:     state_d = IDLE;
            RTURN:   state_d = RDATA;
            RDATA:   state_d = RBACK;
            RBACK:   if (!ulpi_dir_i) state_d = IDLE;
            ABORT:   if (!ulpi_dir_i) state_d = TXCMD;
            RXBUS:   if (!ulpi_dir_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ulpi_data_o = 8'h00;
      busy_o      = 1'b1;
      case (state_q)
         IDLE, RXBUS: busy_o = 1'b0;
         TXCMD:       ulpi_data_o = {1'b1, ~we_q, addr_q};
         WDATA:       ulpi_data_o = wdata_q;
         default:     ;
      endcase
   end

   assign ulpi_stp_o     = (state_q == STP) || tmo_stp_q;
   assign ulpi_data_oe_o = drive_q & ~ulpi_dir_i;
   assign rdata_o        = rdata_q;
   assign done_o         = done_q;
   assign err_o          = err_q;

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == TXCMD && state_q != TXCMD) begin
         cnt_d = '0;
      end else if (counting) begin
         cnt_d = cnt_q + 1'b1;
      end
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (state_q == IDLE && state_d == TXCMD) begin
         we_d    = we_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
      end
      rdata_d   = (state_q == RDATA && !tmo) ? ulpi_data_i : rdata_q;
      done_d    = !tmo && ((state_q == WDATA && state_d == STP) ||
                           (state_q == RBACK && state_d == IDLE));
      err_d     = tmo;
      tmo_stp_d = tmo && !ulpi_dir_i;
      drive_d   = state_d inside {IDLE, TXCMD, WDATA, STP};
   end

   always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= 6'h00;
         wdata_q   <= 8'h00;
         rdata_q   <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tmo_stp_q <= 1'b0;
         drive_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         err_q     <= err_d;
         tmo_stp_q <= tmo_stp_d;
         drive_q   <= drive_d;
      end
   end

`ifdef OUP_ULPI_RXCMD_EN
   logic [7:0] rxcmd_q, rxcmd_d;
   logic       rxcmd_vld_q, rxcmd_vld_d;
   logic       rx_byte;

   // The dir-rising cycle is turnaround and is never sampled here; nxt=1 bytes are packet data.
   assign rx_byte = (state_q == RXBUS || state_q == ABORT) && ulpi_dir_i && !ulpi_nxt_i;

   always_comb begin
      rxcmd_d     = rx_byte ? ulpi_data_i : rxcmd_q;
      rxcmd_vld_d = rx_byte;
   end

   always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxcmd_q     <= 8'h00;
         rxcmd_vld_q <= 1'b0;
      end else begin
         rxcmd_q     <= rxcmd_d;
         rxcmd_vld_q <= rxcmd_vld_d;
      end
   end

   assign rxcmd_o     = rxcmd_q;
   assign rxcmd_vld_o = rxcmd_vld_q;
`else
   assign rxcmd_o     = 8'h00;
   assign rxcmd_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_oup_ulpi_link.sv
// Directed + randomized bench for oup_ulpi_link; the PHY side is a register file shared with a
// separate expected-value register model.
module tb_oup_ulpi_link;
   localparam int TMO = 16;
`ifdef OUP_ULPI_RXCMD_EN
   localparam bit RXON = 1'b1;
`else
   localparam bit RXON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, req, we, dir, nxt;
   logic [5:0] addr;
   logic [7:0] wdata, dat;
   logic [7:0] rdata_o, rxcmd_o, ulpi_data_o;
   logic       done_o, err_o, busy_o, rxcmd_vld_o, ulpi_data_oe_o, ulpi_stp_o;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] phy_regs [64];
   logic [7:0] model_regs [64];
   logic [7:0] last_rdata, exp_rxcmd;

   always #5 clk = ~clk;

   oup_ulpi_link #(.TIMEOUT_CYCLES(TMO)) dut (
      .ulpi_clk_i     (clk),
      .rst_i          (rst),
      .req_i          (req),
      .we_i           (we),
      .addr_i         (addr),
      .wdata_i        (wdata),
      .rdata_o        (rdata_o),
      .done_o         (done_o),
      .err_o          (err_o),
      .busy_o         (busy_o),
      .rxcmd_o        (rxcmd_o),
      .rxcmd_vld_o    (rxcmd_vld_o),
      .ulpi_data_i    (dat),
      .ulpi_data_o    (ulpi_data_o),
      .ulpi_data_oe_o (ulpi_data_oe_o),
      .ulpi_dir_i     (dir),
      .ulpi_nxt_i     (nxt),
      .ulpi_stp_o     (ulpi_stp_o)
   );

   // {data, oe, stp, busy, done, err}
   function automatic logic [12:0] bus_v();
      return {ulpi_data_o, ulpi_data_oe_o, ulpi_stp_o, busy_o, done_o, err_o};
   endfunction

   function automatic logic [7:0] rnd();
      return 8'($urandom);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic d, input logic n, input logic [7:0] x);
      @(negedge clk);
      req = r; dir = d; nxt = n; dat = x;
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] v, input int d1, input int d2,
                           input int ab, input logic [7:0] rxb, input bit keep);
      we = 1'b1; addr = a; wdata = v;
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("wr_accept", bus_v(), {8'h00, 5'b10000});
      if (ab >= 0) begin
         for (int i = 0; i < ab; i++) begin
            cyc(keep, 1'b0, 1'b0, rnd());
            chk("wr_txcmd_pre", bus_v(), {2'b10, a, 5'b10100});
         end
         cyc(keep, 1'b1, 1'b0, rnd());
         chk("ab_turn", bus_v(), {2'b10, a, 5'b00100});
         cyc(keep, 1'b1, 1'b0, rxb);
         chk("ab_rxcmd", bus_v(), {8'h00, 5'b00100});
         cyc(keep, 1'b1, 1'b1, rnd());
         exp_rxcmd = RXON ? rxb : 8'h00;
         chk("ab_pkt", {rxcmd_o, rxcmd_vld_o}, {exp_rxcmd, RXON});
         cyc(keep, 1'b0, 1'b0, rnd());
         chk("ab_release", {rxcmd_o, rxcmd_vld_o, bus_v()}, {exp_rxcmd, 1'b0, 8'h00, 5'b00100});
      end
      for (int i = 0; i <= d1; i++) begin
         cyc(keep, 1'b0, i == d1, rnd());
         chk("wr_txcmd", bus_v(), {2'b10, a, 5'b10100});
      end
      for (int j = 0; j <= d2; j++) begin
         cyc(keep, 1'b0, j == d2, rnd());
         chk("wr_wdata", bus_v(), {v, 5'b10100});
         if (j == d2) phy_regs[a] = ulpi_data_o;
      end
      cyc(keep, 1'b0, 1'b0, rnd());
      chk("wr_stp", bus_v(), {8'h00, 5'b11110});
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("wr_idle", bus_v(), {8'h00, 5'b10000});
      model_regs[a] = v;
   endtask

   task automatic do_read(input logic [5:0] a, input int d1, input int e);
      we = 1'b0; addr = a; wdata = rnd();
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("rd_accept", bus_v(), {8'h00, 5'b10000});
      for (int i = 0; i <= d1; i++) begin
         cyc(1'b1, 1'b0, i == d1, rnd());
         chk("rd_txcmd", bus_v(), {2'b11, a, 5'b10100});
      end
      cyc(1'b1, 1'b1, 1'b0, rnd());
      chk("rd_turn", bus_v(), {8'h00, 5'b00100});
      cyc(1'b1, 1'b1, 1'b0, phy_regs[a]);
      chk("rd_data", bus_v(), {8'h00, 5'b00100});
      for (int k = 0; k < e; k++) begin
         cyc(1'b1, 1'b1, 1'b0, rnd());
         chk("rd_hold", {rdata_o, bus_v()}, {model_regs[a], 8'h00, 5'b00100});
      end
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("rd_back", {rdata_o, bus_v()}, {model_regs[a], 8'h00, 5'b00100});
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("rd_done", {rdata_o, bus_v()}, {model_regs[a], 8'h00, 5'b10010});
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("rd_idle", bus_v(), {8'h00, 5'b10000});
      last_rdata = model_regs[a];
   endtask

   task automatic do_timeout(input logic [5:0] a);
      we = 1'b0; addr = a;
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("to_accept", bus_v(), {8'h00, 5'b10000});
      for (int i = 0; i < TMO; i++) begin
         cyc(1'b1, 1'b0, 1'b0, rnd());
         chk("to_wait", bus_v(), {2'b11, a, 5'b10100});
      end
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("to_err", {rdata_o, bus_v()}, {last_rdata, 8'h00, 5'b11001});
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("to_idle", bus_v(), {8'h00, 5'b10000});
   endtask

   task automatic do_rxbus(input int n);
      logic       pend;
      logic       nx;
      logic [7:0] b;
      pend = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, rnd());
      chk("rx_turn", {rxcmd_o, rxcmd_vld_o, ulpi_data_oe_o}, {exp_rxcmd, 1'b0, 1'b0});
      for (int k = 0; k < n; k++) begin
         nx = 1'($urandom_range(0, 1));
         b  = rnd();
         cyc(1'b0, 1'b1, nx, b);
         chk("rx_byte", {rxcmd_o, rxcmd_vld_o, ulpi_data_oe_o}, {exp_rxcmd, pend, 1'b0});
         pend = RXON && !nx;
         if (pend) exp_rxcmd = b;
      end
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("rx_release", {rxcmd_o, rxcmd_vld_o, ulpi_data_oe_o}, {exp_rxcmd, pend, 1'b0});
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("rx_idle", {rxcmd_o, rxcmd_vld_o, ulpi_data_oe_o}, {exp_rxcmd, 1'b0, 1'b1});
   endtask

   task automatic do_reset_in_wdata(input logic [5:0] a, input logic [7:0] v);
      we = 1'b1; addr = a; wdata = v;
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("rw_accept", bus_v(), {8'h00, 5'b10000});
      cyc(1'b1, 1'b0, 1'b1, rnd());
      chk("rw_txcmd", bus_v(), {2'b10, a, 5'b10100});
      cyc(1'b1, 1'b0, 1'b0, rnd());
      chk("rw_wdata", bus_v(), {v, 5'b10100});
      @(negedge clk);
      rst = 1'b1; req = 1'b0; nxt = 1'b0;
      #1;
      chk("rst_async", {rdata_o, rxcmd_o, rxcmd_vld_o, bus_v()}, 32'h0);
      last_rdata = 8'h00;
      exp_rxcmd  = 8'h00;
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("rst_hold", {rdata_o, bus_v()}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, rnd());
      chk("rst_idle", bus_v(), {8'h00, 5'b10000});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 6'h00; wdata = 8'h00;
      dir = 1'b0; nxt = 1'b0; dat = 8'h00;
      last_rdata = 8'h00; exp_rxcmd = 8'h00;
      for (int i = 0; i < 64; i++) begin
         phy_regs[i]   = rnd();
         model_regs[i] = phy_regs[i];
      end
      #1;
      chk("reset_state", {rdata_o, rxcmd_o, rxcmd_vld_o, bus_v()}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("post_reset_idle", bus_v(), {8'h00, 5'b10000});

      do_write(6'h0A, 8'h55, 2, 2, -1, 8'h00, 1'b1);
      phy_regs[0] = 8'h24; model_regs[0] = 8'h24;
      do_read(6'h00, 2, 0);
      do_write(6'h05, 8'h3C, 1, 0, 1, 8'h4C, 1'b1);
      do_read(6'h05, 0, 1);
      do_write(6'h07, 8'hE1, 0, 3, -1, 8'h00, 1'b0);
      do_read(6'h07, 1, 0);
      do_timeout(6'h11);
      do_rxbus(6);
      do_reset_in_wdata(6'h0A, 8'h99);
      do_write(6'h0A, 8'hA3, 1, 1, -1, 8'h00, 1'b1);
      do_read(6'h0A, 0, 2);

      for (int t = 0; t < 16; t++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0, 1: do_write(6'($urandom_range(0, 7)), rnd(), int'($urandom_range(0, 4)),
                           int'($urandom_range(0, 4)), -1, 8'h00, 1'($urandom_range(0, 1)));
            2:    do_write(6'($urandom_range(0, 7)), rnd(), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd(), 1'b1);
            3:    do_read(6'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 2)));
            default: do_rxbus(int'($urandom_range(1, 5)));
         endcase
      end
      for (int r = 0; r < 8; r++) begin
         do_read(6'(r), int'($urandom_range(0, 3)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
